// File: rtl/des3_seq_ctrl.sv
// Sequencer for the iterative triple-DES core: accepts one block, walks
// roundSel through every core iteration, captures the result and holds it
// until the consumer takes it.
module des3_seq_ctrl #(
  parameter int unsigned NUM_ROUNDS  = 48,
  parameter int unsigned CAPTURE_DLY = 1,
  parameter int unsigned RS_W        = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  input  logic [55:0]     in_key1,
  input  logic [55:0]     in_key2,
  input  logic [55:0]     in_key3,
  input  logic            in_decrypt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic [63:0]     core_desIn,
  output logic [55:0]     core_key1,
  output logic [55:0]     core_key2,
  output logic [55:0]     core_key3,
  output logic            core_decrypt,
  output logic [RS_W-1:0] core_roundSel,
  input  logic [63:0]     core_desOut,
  output logic            busy,
  output logic [15:0]     blk_count
);

  localparam int unsigned CNT_W = 2;
  localparam logic [RS_W-1:0] LAST_RS = RS_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  dly_cnt;
  logic [CNT_W-1:0]  dly_cnt_nxt;
  logic [RS_W-1:0]   rs_nxt;
  logic [63:0]       out_data_nxt;
  logic [63:0]       din_nxt;
  logic [55:0]       key1_nxt;
  logic [55:0]       key2_nxt;
  logic [55:0]       key3_nxt;
  logic              dec_nxt;
  logic [15:0]       blk_nxt;
  logic              in_ready_nxt;
  logic              out_valid_nxt;
  logic              busy_nxt;

  // State and datapath registers; status flags are registered from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      dly_cnt       <= '0;
      core_roundSel <= '0;
      out_data      <= '0;
      core_desIn    <= '0;
      core_key1     <= '0;
      core_key2     <= '0;
      core_key3     <= '0;
      core_decrypt  <= 1'b0;
      blk_count     <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      dly_cnt       <= dly_cnt_nxt;
      core_roundSel <= rs_nxt;
      out_data      <= out_data_nxt;
      core_desIn    <= din_nxt;
      core_key1     <= key1_nxt;
      core_key2     <= key2_nxt;
      core_key3     <= key3_nxt;
      core_decrypt  <= dec_nxt;
      blk_count     <= blk_nxt;
      in_ready      <= in_ready_nxt;
      out_valid     <= out_valid_nxt;
      busy          <= busy_nxt;
    end
  end

  // Next-state and next-value logic for the round sequencer
  always_comb begin
    state_nxt    = state;
    dly_cnt_nxt  = dly_cnt;
    rs_nxt       = core_roundSel;
    out_data_nxt = out_data;
    din_nxt      = core_desIn;
    key1_nxt     = core_key1;
    key2_nxt     = core_key2;
    key3_nxt     = core_key3;
    dec_nxt      = core_decrypt;
    blk_nxt      = blk_count;

    case (state)
      S_IDLE: begin
        rs_nxt = '0;
        if (in_valid && in_ready) begin
          din_nxt   = in_data;
          key1_nxt  = in_key1;
          key2_nxt  = in_key2;
          key3_nxt  = in_key3;
          dec_nxt   = in_decrypt;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (core_roundSel == LAST_RS) begin
          if (CAPTURE_DLY == 0) begin
            out_data_nxt = core_desOut;
            state_nxt    = S_DONE;
          end else begin
            dly_cnt_nxt = CNT_W'(CAPTURE_DLY - 1);
            state_nxt   = S_WAIT;
          end
        end else begin
          rs_nxt = core_roundSel + RS_W'(1);
        end
      end
      S_WAIT: begin
        if (dly_cnt == '0) begin
          out_data_nxt = core_desOut;
          state_nxt    = S_DONE;
        end else begin
          dly_cnt_nxt = dly_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          blk_nxt   = blk_count + 16'd1;
          rs_nxt    = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    in_ready_nxt  = (state_nxt == S_IDLE);
    out_valid_nxt = (state_nxt == S_DONE);
    busy_nxt      = (state_nxt == S_RUN) || (state_nxt == S_WAIT);
  end

endmodule
